// File: rtl/dram_rd_checker.sv
// Read-data checker for the DRAM bandwidth test: it compares the read beats against the
// incrementing-counter write pattern and reports the beat, error, cycle and stray counts.
module dram_rd_checker #(
  parameter int DATA_WIDTH = 512,
  parameter int CNT_WIDTH  = 32,
  parameter int TIMEOUT    = 65536
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [CNT_WIDTH-1:0]  ELEM,
  input  logic [CNT_WIDTH-1:0]  SEED,
  input  logic [DATA_WIDTH-1:0] DOUT,
  input  logic                  DOUTEN,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  PASS,
  output logic                  TIMED_OUT,
  output logic [CNT_WIDTH-1:0]  BEAT_CNT,
  output logic [CNT_WIDTH-1:0]  ERR_CNT,
  output logic [CNT_WIDTH-1:0]  FIRST_ERR_IDX,
  output logic [31:0]           FIRST_ERR_DATA,
  output logic [CNT_WIDTH-1:0]  CYCLE_CNT,
  output logic [CNT_WIDTH-1:0]  STRAY_CNT
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_V = CNT_WIDTH'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t                  state;
  logic [CNT_WIDTH-1:0]    elem_q;
  logic [31:0]             exp_q;
  logic [CNT_WIDTH-1:0]    idle_cnt;
  logic [DATA_WIDTH-1:0]   exp_word;
  logic                    mismatch;
  logic [CNT_WIDTH-1:0]    beat_inc;
  logic [CNT_WIDTH-1:0]    idle_inc;
  logic                    idle_expired;

  // Expected beat is the 32-bit counter zero-extended; any upper bit set is an error.
  always_comb begin
    exp_word        = '0;
    exp_word[31:0]  = exp_q;
    mismatch        = (DOUT != exp_word);
    beat_inc        = BEAT_CNT + CNT_ONE;
    idle_inc        = idle_cnt + CNT_ONE;
    idle_expired    = (TIMEOUT != 0) && (idle_inc == TIMEOUT_V);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state          <= IDLE;
      elem_q         <= '0;
      exp_q          <= '0;
      idle_cnt       <= '0;
      BUSY           <= 1'b0;
      DONE           <= 1'b0;
      PASS           <= 1'b0;
      TIMED_OUT      <= 1'b0;
      BEAT_CNT       <= '0;
      ERR_CNT        <= '0;
      FIRST_ERR_IDX  <= '0;
      FIRST_ERR_DATA <= '0;
      CYCLE_CNT      <= '0;
      STRAY_CNT      <= '0;
    end else begin
      DONE <= 1'b0;
      if (DOUTEN && state != RUN && STRAY_CNT != CNT_MAX)
        STRAY_CNT <= STRAY_CNT + CNT_ONE;
      case (state)
        // The DONE cycle accepts a new START exactly like IDLE does.
        IDLE, FIN: begin
          state <= IDLE;
          if (START) begin
            elem_q         <= ELEM;
            exp_q          <= SEED[31:0];
            idle_cnt       <= '0;
            BEAT_CNT       <= '0;
            ERR_CNT        <= '0;
            FIRST_ERR_IDX  <= '0;
            FIRST_ERR_DATA <= '0;
            CYCLE_CNT      <= '0;
            TIMED_OUT      <= 1'b0;
            if (ELEM == '0) begin
              state <= FIN;
              DONE  <= 1'b1;
              PASS  <= 1'b1;
            end else begin
              state <= RUN;
              BUSY  <= 1'b1;
              PASS  <= 1'b0;
            end
          end
        end
        RUN: begin
          if (CYCLE_CNT != CNT_MAX)
            CYCLE_CNT <= CYCLE_CNT + CNT_ONE;
          if (DOUTEN) begin
            exp_q    <= exp_q + 32'd1;
            BEAT_CNT <= beat_inc;
            idle_cnt <= '0;
            if (mismatch) begin
              if (ERR_CNT != CNT_MAX)
                ERR_CNT <= ERR_CNT + CNT_ONE;
              if (ERR_CNT == '0) begin
                FIRST_ERR_IDX  <= BEAT_CNT;
                FIRST_ERR_DATA <= DOUT[31:0];
              end
            end
            if (beat_inc == elem_q) begin
              state <= FIN;
              BUSY  <= 1'b0;
              DONE  <= 1'b1;
              PASS  <= (ERR_CNT == '0) && !mismatch;
            end
          end else if (idle_expired) begin
            state     <= FIN;
            BUSY      <= 1'b0;
            DONE      <= 1'b1;
            TIMED_OUT <= 1'b1;
            PASS      <= 1'b0;
          end else begin
            idle_cnt <= idle_inc;
          end
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dram_rd_checker.sv
// Self-checking bench for dram_rd_checker: directed and random checks scored against a
// beat-list reference model that derives results from the pattern rules directly.
module tb_dram_rd_checker;

  localparam int TO = 16;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         START = 1'b0;
  logic [31:0]  ELEM = '0;
  logic [31:0]  SEED = '0;
  logic [511:0] DOUT = '0;
  logic         DOUTEN = 1'b0;
  logic         BUSY, DONE, PASS, TIMED_OUT;
  logic [31:0]  BEAT_CNT, ERR_CNT, FIRST_ERR_IDX, FIRST_ERR_DATA, CYCLE_CNT, STRAY_CNT;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int m_stray  = 0;
  logic [511:0] q_beats[$];
  int           q_gaps[$];

  dram_rd_checker #(.DATA_WIDTH(512), .CNT_WIDTH(32), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .START(START), .ELEM(ELEM), .SEED(SEED), .DOUT(DOUT),
    .DOUTEN(DOUTEN), .BUSY(BUSY), .DONE(DONE), .PASS(PASS), .TIMED_OUT(TIMED_OUT),
    .BEAT_CNT(BEAT_CNT), .ERR_CNT(ERR_CNT), .FIRST_ERR_IDX(FIRST_ERR_IDX),
    .FIRST_ERR_DATA(FIRST_ERR_DATA), .CYCLE_CNT(CYCLE_CNT), .STRAY_CNT(STRAY_CNT)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [511:0] mk(input logic [31:0] v);
    mk = '0;
    mk[31:0] = v;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Runs one check from q_beats/q_gaps; the model walks the beat list to get the results.
  task automatic test_run(input string name, input logic [31:0] elem, input logic [31:0] seed,
                          input int mid_start);
    logic [511:0] want;
    logic [31:0]  m_idx, m_data, hold_beats;
    logic         m_pass, m_to, m_done;
    int           m_beats, m_err, m_end, pos, t, waited;
    m_beats = 0; m_err = 0; m_idx = '0; m_data = '0; m_to = 1'b0; pos = 0; m_end = 0;
    m_done = (elem == 32'd0);
    for (int i = 0; i < q_beats.size() && !m_done; i++) begin
      pos += q_gaps[i] + 1;
      m_beats++;
      want = mk(seed + 32'(i));
      if (q_beats[i] !== want) begin
        if (m_err == 0) begin
          m_idx  = 32'(i);
          m_data = q_beats[i][31:0];
        end
        m_err++;
      end
      if (32'(m_beats) == elem) begin
        m_done = 1'b1;
        m_end  = pos;
      end
    end
    if (!m_done) begin
      m_to  = 1'b1;
      m_end = pos + TO;
    end
    m_pass = !m_to && (m_err == 0);

    step();
    START = 1'b1; ELEM = elem; SEED = seed;
    step();
    t = cyc;
    START = 1'b0; ELEM = $urandom; SEED = $urandom;
    if (elem != 32'd0) begin
      n_checks++;
      if (BUSY !== 1'b1) begin n_fail++; $display("[TB] FAIL %s busy_after_start: got %b want 1", name, BUSY); end
    end
    for (int i = 0; i < m_beats; i++) begin
      repeat (q_gaps[i]) step();
      DOUT = q_beats[i];
      DOUTEN = 1'b1;
      if (i == mid_start) begin
        START = 1'b1; ELEM = 32'd7; SEED = $urandom;
      end
      step();
      DOUTEN = 1'b0; START = 1'b0; DOUT = mk($urandom);
    end
    waited = 0;
    while (DONE !== 1'b1 && waited < TO + 20) begin
      step();
      waited++;
    end
    n_checks++;
    if (DONE !== 1'b1) begin n_fail++; $display("[TB] FAIL %s done_seen: got %b want 1", name, DONE); end
    n_checks++;
    if (cyc - t != m_end) begin n_fail++; $display("[TB] FAIL %s done_latency: got %0d want %0d", name, cyc - t, m_end); end
    n_checks++;
    if (BUSY !== 1'b0) begin n_fail++; $display("[TB] FAIL %s busy_at_done: got %b want 0", name, BUSY); end
    n_checks++;
    if (PASS !== m_pass) begin n_fail++; $display("[TB] FAIL %s pass: got %b want %b", name, PASS, m_pass); end
    n_checks++;
    if (TIMED_OUT !== m_to) begin n_fail++; $display("[TB] FAIL %s timed_out: got %b want %b", name, TIMED_OUT, m_to); end
    n_checks++;
    if (BEAT_CNT !== 32'(m_beats)) begin n_fail++; $display("[TB] FAIL %s beat_cnt: got %0d want %0d", name, BEAT_CNT, m_beats); end
    n_checks++;
    if (ERR_CNT !== 32'(m_err)) begin n_fail++; $display("[TB] FAIL %s err_cnt: got %0d want %0d", name, ERR_CNT, m_err); end
    n_checks++;
    if (FIRST_ERR_IDX !== m_idx) begin n_fail++; $display("[TB] FAIL %s first_err_idx: got %0d want %0d", name, FIRST_ERR_IDX, m_idx); end
    n_checks++;
    if (FIRST_ERR_DATA !== m_data) begin n_fail++; $display("[TB] FAIL %s first_err_data: got %h want %h", name, FIRST_ERR_DATA, m_data); end
    n_checks++;
    if (CYCLE_CNT !== 32'(m_end)) begin n_fail++; $display("[TB] FAIL %s cycle_cnt: got %0d want %0d", name, CYCLE_CNT, m_end); end
    n_checks++;
    if (STRAY_CNT !== 32'(m_stray)) begin n_fail++; $display("[TB] FAIL %s stray_cnt: got %0d want %0d", name, STRAY_CNT, m_stray); end
    hold_beats = BEAT_CNT;
    step();
    n_checks++;
    if (DONE !== 1'b0) begin n_fail++; $display("[TB] FAIL %s done_pulse_width: got %b want 0", name, DONE); end
    n_checks++;
    if (PASS !== m_pass || BEAT_CNT !== hold_beats) begin
      n_fail++; $display("[TB] FAIL %s hold_after_done: got pass=%b beats=%0d want pass=%b beats=%0d", name, PASS, BEAT_CNT, m_pass, hold_beats);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) step();
    n_checks++;
    if ({BUSY, DONE, PASS, TIMED_OUT} !== 4'b0 || BEAT_CNT !== 0 || ERR_CNT !== 0 || CYCLE_CNT !== 0 ||
        STRAY_CNT !== 0 || FIRST_ERR_IDX !== 0 || FIRST_ERR_DATA !== 0) begin
      n_fail++; $display("[TB] FAIL reset_outputs: got busy=%b done=%b pass=%b beats=%0d want all 0", BUSY, DONE, PASS, BEAT_CNT);
    end
    RST = 1'b0;
    step();
  endtask

  task automatic test_stray();
    repeat (3) begin
      DOUTEN = 1'b1; DOUT = mk($urandom);
      step();
    end
    DOUTEN = 1'b0;
    m_stray += 3;
    step();
    n_checks++;
    if (STRAY_CNT !== 32'(m_stray) || BEAT_CNT !== 0) begin
      n_fail++; $display("[TB] FAIL stray_before_start: got stray=%0d beats=%0d want %0d and 0", STRAY_CNT, BEAT_CNT, m_stray);
    end
  endtask

  task automatic test_directed();
    q_beats = {}; q_gaps = {};
    for (int i = 0; i < 4; i++) begin q_beats.push_back(mk(32'(i))); q_gaps.push_back(0); end
    test_run("basic_b2b", 32'd4, 32'd0, -1);
    q_beats = {mk(10), mk(11), mk(99), mk(13), mk(77)}; q_gaps = {2, 0, 3, 1, 4};
    test_run("errors_gaps", 32'd5, 32'd10, -1);
    q_beats = {mk(32'hFFFFFFFE), mk(32'hFFFFFFFF), mk(32'h0)}; q_gaps = {0, 1, 0};
    test_run("wrap32", 32'd3, 32'hFFFFFFFE, -1);
    q_beats = {mk(5), mk(6), mk(7)}; q_gaps = {0, 0, 0};
    q_beats[1][300] = 1'b1;
    test_run("upper_bit", 32'd3, 32'd5, -1);
    q_beats = {mk(40), mk(41)}; q_gaps = {1, 2};
    test_run("timeout", 32'd4, 32'd40, -1);
    q_beats = {}; q_gaps = {};
    for (int i = 0; i < 6; i++) begin q_beats.push_back(mk(32'(100 + i))); q_gaps.push_back(i % 2); end
    test_run("mid_start", 32'd6, 32'd100, 2);
    q_beats = {}; q_gaps = {};
    test_run("elem_zero", 32'd0, 32'd3, -1);
  endtask

  // A START in the DONE cycle must relaunch the check while the DONE pulse still shows.
  task automatic test_back_to_back();
    step();
    START = 1'b1; ELEM = 32'd1; SEED = 32'd5;
    step();
    START = 1'b0;
    DOUTEN = 1'b1; DOUT = mk(5);
    step();
    DOUTEN = 1'b0;
    START = 1'b1; ELEM = 32'd2; SEED = 32'd20;
    n_checks++;
    if (DONE !== 1'b1 || PASS !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_first_done: got done=%b pass=%b want 1 1", DONE, PASS); end
    step();
    START = 1'b0;
    n_checks++;
    if (BUSY !== 1'b1 || DONE !== 1'b0 || PASS !== 1'b0 || BEAT_CNT !== 0) begin
      n_fail++; $display("[TB] FAIL b2b_restart: got busy=%b done=%b pass=%b beats=%0d want 1 0 0 0", BUSY, DONE, PASS, BEAT_CNT);
    end
    DOUTEN = 1'b1; DOUT = mk(20);
    step();
    DOUT = mk(21);
    step();
    DOUTEN = 1'b0;
    n_checks++;
    if (DONE !== 1'b1 || PASS !== 1'b1 || BEAT_CNT !== 2 || CYCLE_CNT !== 2) begin
      n_fail++; $display("[TB] FAIL b2b_second_done: got done=%b pass=%b beats=%0d cycles=%0d want 1 1 2 2", DONE, PASS, BEAT_CNT, CYCLE_CNT);
    end
    step();
  endtask

  task automatic test_random();
    logic [31:0]  elem, seed;
    logic [511:0] v;
    int           bit_idx, n_beats;
    for (int r = 0; r < 15; r++) begin
      elem = 32'($urandom_range(12, 1));
      seed = ($urandom_range(1, 0) == 1) ? (32'hFFFFFFFF - 32'($urandom_range(6, 0))) : $urandom;
      n_beats = ($urandom_range(4, 0) == 0) ? int'(elem) - 1 : int'(elem);
      q_beats = {}; q_gaps = {};
      for (int i = 0; i < n_beats; i++) begin
        v = mk(seed + 32'(i));
        if ($urandom_range(3, 0) == 0) begin
          bit_idx = $urandom_range(511, 0);
          v[bit_idx] = ~v[bit_idx];
        end
        q_beats.push_back(v);
        q_gaps.push_back($urandom_range(3, 0));
      end
      test_run("random", elem, seed, ($urandom_range(3, 0) == 0) ? 0 : -1);
    end
  endtask

  task automatic test_reset_mid_run();
    step();
    START = 1'b1; ELEM = 32'd8; SEED = 32'd0;
    step();
    START = 1'b0;
    DOUTEN = 1'b1; DOUT = mk(0);
    step();
    DOUT = mk(5);
    step();
    DOUTEN = 1'b0;
    n_checks++;
    if (BEAT_CNT !== 2 || ERR_CNT !== 1 || BUSY !== 1'b1) begin
      n_fail++; $display("[TB] FAIL rst_pre_state: got beats=%0d errs=%0d busy=%b want 2 1 1", BEAT_CNT, ERR_CNT, BUSY);
    end
    RST = 1'b1;
    step();
    RST = 1'b0;
    m_stray = 0;
    n_checks++;
    if ({BUSY, DONE, PASS, TIMED_OUT} !== 4'b0 || BEAT_CNT !== 0 || ERR_CNT !== 0 || CYCLE_CNT !== 0 ||
        STRAY_CNT !== 0 || FIRST_ERR_IDX !== 0 || FIRST_ERR_DATA !== 0) begin
      n_fail++; $display("[TB] FAIL rst_mid_run: got busy=%b beats=%0d errs=%0d idx=%0d data=%h want all 0", BUSY, BEAT_CNT, ERR_CNT, FIRST_ERR_IDX, FIRST_ERR_DATA);
    end
    q_beats = {mk(32'd77)}; q_gaps = {0};
    test_run("after_reset", 32'd1, 32'd77, -1);
  endtask

  initial begin
    test_reset();
    test_stray();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
